// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the Sargantana instruction cache.
//   ifill_arb_state_t : IFILL arbiter sequencing states
//   ifill_owner_t     : which requester owns the line fill in flight
//   DEF_*             : default address/line geometry used by the IFILL arbiter
package sargantana_icache_pkg;

  localparam int unsigned DEF_PADDR_W    = 40;
  localparam int unsigned DEF_LINE_OFF_W = 6;
  localparam int unsigned DEF_BEATS      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ifill_arb_state_t;

  typedef enum logic {
    OWN_DMD = 1'b0,
    OWN_PF  = 1'b1
  } ifill_owner_t;

endpackage

// File: rtl/sargantana_icache_ifill_arb.sv
// IFILL port arbiter and sequencer. Shares the single IFILL request/response
// channel between the demand-miss path and an optional next-line prefetcher,
// tracks one outstanding line fill, steers response beats to the cache write
// port, merges a demand miss onto an in-flight prefetch of the same line and
// drains the beats of killed or flushed fills.
//
// Build option: ICACHE_IFILL_PREFETCH_EN
//   defined   : prefetch acceptance, prefetch ownership and demand merge
//   undefined : pf_req_ready_o and fill_is_pf_o tied low; pf ports unused
//
// Ports
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   dmd_req_*                demand miss request (valid/paddr/ready)
//   dmd_kill_i, flush_i      kill current demand / kill everything
//   pf_req_*                 prefetch request (valid/paddr/ready)
//   ifill_req_*              request to upper level (valid/paddr/ready)
//   ifill_resp_valid_i       response beat valid
//   wr_ena_o, wr_beat_o      cache write strobe and beat index
//   fill_is_pf_o             current fill belongs to the prefetcher
//   fill_done_o              last beat of a non-dropped fill
//   dmd_resp_valid_o         demand line available
//   busy_o                   arbiter not idle
module sargantana_icache_ifill_arb
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned PADDR_W    = DEF_PADDR_W,
  parameter int unsigned LINE_OFF_W = DEF_LINE_OFF_W,
  parameter int unsigned BEATS      = DEF_BEATS,
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               dmd_req_valid_i,
  input  logic [PADDR_W-1:0] dmd_req_paddr_i,
  output logic               dmd_req_ready_o,
  input  logic               dmd_kill_i,
  input  logic               flush_i,
  input  logic               pf_req_valid_i,
  input  logic [PADDR_W-1:0] pf_req_paddr_i,
  output logic               pf_req_ready_o,
  output logic               ifill_req_valid_o,
  output logic [PADDR_W-1:0] ifill_req_paddr_o,
  input  logic               ifill_req_ready_i,
  input  logic               ifill_resp_valid_i,
  output logic               wr_ena_o,
  output logic [BEAT_W-1:0]  wr_beat_o,
  output logic               fill_is_pf_o,
  output logic               fill_done_o,
  output logic               dmd_resp_valid_o,
  output logic               busy_o
);

  localparam int unsigned      LINE_W    = PADDR_W - LINE_OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  ifill_arb_state_t  state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic              killed_q, killed_d;

  logic              is_pf;
  logic              merged;
  logic              merge_ok;
  logic              kill_hit;
  logic              last_beat;
  logic              dmd_rdy;
  logic              pf_rdy;
  logic [LINE_W-1:0] dmd_line;

  assign dmd_line  = dmd_req_paddr_i[PADDR_W-1:LINE_OFF_W];
  assign last_beat = (cnt_q == LAST_BEAT);
  // A demand kill only touches the fill when the demand owns it outright.
  assign kill_hit  = flush_i || (dmd_kill_i && !is_pf);

`ifdef ICACHE_IFILL_PREFETCH_EN
  ifill_owner_t owner_q, owner_d;
  logic         merged_q, merged_d;
  logic         own_load;
  logic         own_load_pf;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^{dmd_req_paddr_i[LINE_OFF_W-1:0], pf_req_paddr_i[LINE_OFF_W-1:0]};

  assign is_pf  = (owner_q == OWN_PF);
  assign merged = merged_q;

  // A demand may piggy-back on a live prefetch of the same line; a prefetch
  // already condemned by a flush in REQ must not absorb a new demand.
  assign merge_ok = is_pf && ((state_q == REQ) || (state_q == WAIT)) && !killed_q &&
                    dmd_req_valid_i && (dmd_line == line_q) && !dmd_kill_i && !flush_i;

  always_comb begin
    owner_d  = owner_q;
    merged_d = merged_q;
    if (own_load) begin
      owner_d  = own_load_pf ? OWN_PF : OWN_DMD;
      merged_d = 1'b0;
    end else begin
      if (flush_i || dmd_kill_i) merged_d = 1'b0;
      if (merge_ok)              merged_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_q  <= OWN_DMD;
      merged_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      merged_q <= merged_d;
    end
  end
`else
  logic unused_pf_bits;

  assign unused_pf_bits = ^{pf_req_valid_i, pf_req_paddr_i, dmd_req_paddr_i[LINE_OFF_W-1:0]};

  assign is_pf    = 1'b0;
  assign merged   = 1'b0;
  assign merge_ok = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    line_d           = line_q;
    cnt_d            = cnt_q;
    killed_d         = killed_q;
    dmd_rdy          = 1'b0;
    pf_rdy           = 1'b0;
    wr_ena_o         = 1'b0;
    fill_done_o      = 1'b0;
    dmd_resp_valid_o = 1'b0;
`ifdef ICACHE_IFILL_PREFETCH_EN
    own_load         = 1'b0;
    own_load_pf      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        dmd_rdy = !dmd_kill_i && !flush_i;
`ifdef ICACHE_IFILL_PREFETCH_EN
        pf_rdy  = !dmd_req_valid_i && !flush_i;
`endif
        if (dmd_req_valid_i && dmd_rdy) begin
          line_d   = dmd_line;
          killed_d = 1'b0;
          state_d  = REQ;
`ifdef ICACHE_IFILL_PREFETCH_EN
          own_load = 1'b1;
        end else if (pf_req_valid_i && pf_rdy) begin
          line_d      = pf_req_paddr_i[PADDR_W-1:LINE_OFF_W];
          killed_d    = 1'b0;
          state_d     = REQ;
          own_load    = 1'b1;
          own_load_pf = 1'b1;
`endif
        end
      end
      REQ: begin
        // The request stays up until accepted; a kill only marks it so its
        // beats are discarded later.
        dmd_rdy = merge_ok;
        if (kill_hit) killed_d = 1'b1;
        if (ifill_req_ready_i) begin
          cnt_d   = '0;
          state_d = (killed_q || kill_hit) ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        dmd_rdy = merge_ok;
        if (ifill_resp_valid_i) begin
          cnt_d = cnt_q + BEAT_W'(1);
          if (!kill_hit) begin
            wr_ena_o = 1'b1;
            if (last_beat) begin
              fill_done_o      = 1'b1;
              // A demand merging on the final beat still sees the line written.
              dmd_resp_valid_o = !is_pf || (merged && !dmd_kill_i) || merge_ok;
            end
          end
          if (last_beat)     state_d = IDLE;
          else if (kill_hit) state_d = DRAIN;
        end else if (kill_hit) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ifill_resp_valid_i) begin
          cnt_d = cnt_q + BEAT_W'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake readies are held low while reset is asserted.
  assign dmd_req_ready_o   = dmd_rdy && rstn_i;
  assign pf_req_ready_o    = pf_rdy && rstn_i;
  assign ifill_req_valid_o = (state_q == REQ);
  assign ifill_req_paddr_o = {line_q, {LINE_OFF_W{1'b0}}};
  assign wr_beat_o         = cnt_q;
  assign fill_is_pf_o      = is_pf;
  assign busy_o            = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      line_q   <= '0;
      cnt_q    <= '0;
      killed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      cnt_q    <= cnt_d;
      killed_q <= killed_d;
    end
  end

endmodule
